// File: rtl/conv_group_acc_pkg.sv
// Shared defaults, sideband layout and a constant log2 helper for the
// convolution group-sum datapath.
package conv_group_acc_pkg;

  localparam int DEF_NUM_IN = 4;
  localparam int DEF_IN_W   = 16;
  localparam int DEF_OUT_W  = 20;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } sb_t;

  localparam int SB_BITS = $bits(sb_t);

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Registered signed pairwise adder tree, log2(NUM_IN) cycles, always enabled
// (no backpressure); an opaque sideband bus travels alongside with equal delay.
module conv_adder_tree
  import conv_group_acc_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int IN_W    = DEF_IN_W,
  parameter int SB_W    = SB_BITS,
  localparam int LVLS   = clog2(NUM_IN),
  localparam int SUM_W  = IN_W + LVLS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*IN_W-1:0]   i_data,
  input  logic [SB_W-1:0]          i_sb,
  output logic signed [SUM_W-1:0]  o_sum,
  output logic [SB_W-1:0]          o_sb
);

  // Heap layout: node k sums children 2k and 2k+1; leaves NUM_IN..2*NUM_IN-1
  // are the input lanes, node 1 is the root. Every leaf sits L levels deep.
  logic signed [SUM_W-1:0] w_node [1:2*NUM_IN-1];
  logic signed [SUM_W-1:0] r_node [1:NUM_IN-1];
  logic [SB_W-1:0]         r_sb   [1:LVLS];

  always_comb begin
    for (int k = 1; k < NUM_IN; k++) begin
      w_node[k] = r_node[k];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      w_node[NUM_IN + i] = SUM_W'($signed(i_data[i*IN_W +: IN_W]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k < NUM_IN; k++) begin
        r_node[k] <= '0;
      end
      for (int k = 1; k <= LVLS; k++) begin
        r_sb[k] <= '0;
      end
    end else begin
      for (int k = 1; k < NUM_IN; k++) begin
        r_node[k] <= w_node[2*k] + w_node[2*k+1];
      end
      r_sb[1] <= i_sb;
      for (int k = 2; k <= LVLS; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  assign o_sum = w_node[1];
  assign o_sb  = r_sb[LVLS];

endmodule

// File: rtl/conv_group_acc.sv
// Reduces NUM_IN lanes per beat and accumulates beats framed by first/last into
// one saturating/wrapping group sum; latency log2(NUM_IN)+1, no backpressure.
module conv_group_acc
  import conv_group_acc_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter bit SAT_EN  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [NUM_IN*IN_W-1:0]   in_data,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_overflow
);

  localparam int LVLS  = clog2(NUM_IN);
  localparam int SUM_W = IN_W + LVLS;
  localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [NUM_IN*IN_W-1:0]  r_in_data;
  sb_t                     r_in_sb;
  sb_t                     w_sb_out;
  logic signed [SUM_W-1:0] w_sum;

  logic signed [OUT_W-1:0] r_acc;
  logic                    r_open;
  logic                    r_sticky;

  logic                    w_fresh;
  logic signed [OUT_W:0]   w_acc_ext;
  logic signed [OUT_W:0]   w_sum_ext;
  logic signed [OUT_W:0]   w_n;
  logic                    w_ovf;
  logic signed [OUT_W-1:0] w_n_fit;
  logic                    w_sticky;

  // Boundary capture stage from the PE array; the tree then adds L levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_data <= '0;
      r_in_sb   <= '0;
    end else begin
      r_in_data <= in_data;
      r_in_sb   <= '{vld: in_valid, first: in_first, last: in_last};
    end
  end

  conv_adder_tree #(
    .NUM_IN (NUM_IN),
    .IN_W   (IN_W),
    .SB_W   (SB_BITS)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .i_data (r_in_data),
    .i_sb   (r_in_sb),
    .o_sum  (w_sum),
    .o_sb   (w_sb_out)
  );

  // A beat with no group open behaves as an implicit first.
  always_comb begin
    w_fresh   = w_sb_out.first || !r_open;
    w_sum_ext = (OUT_W+1)'(w_sum);
    w_acc_ext = w_fresh ? '0 : (OUT_W+1)'(r_acc);
    w_n       = w_acc_ext + w_sum_ext;
    w_ovf     = (w_n[OUT_W] != w_n[OUT_W-1]);
    if (SAT_EN && w_ovf) begin
      w_n_fit = w_n[OUT_W] ? SAT_MIN : SAT_MAX;
    end else begin
      w_n_fit = w_n[OUT_W-1:0];
    end
    w_sticky  = w_ovf || (!w_fresh && r_sticky);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc        <= '0;
      r_open       <= 1'b0;
      r_sticky     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (w_sb_out.vld) begin
        if (w_sb_out.last) begin
          out_valid    <= 1'b1;
          out_data     <= w_n_fit;
          out_overflow <= w_sticky;
          r_acc        <= '0;
          r_open       <= 1'b0;
          r_sticky     <= 1'b0;
        end else begin
          r_acc        <= w_n_fit;
          r_open       <= 1'b1;
          r_sticky     <= w_sticky;
        end
      end
    end
  end

endmodule

// File: doc/conv_group_acc.md
Name: conv_group_acc

Overview:
Parametrised, pipelined signed adder tree that reduces NUM_IN partial convolution results per beat to one sum. Successive beats are accumulated across a group of input-channel passes framed by first/last flags, with saturation and an overflow flag. Sits after the systolic PE array and replaces the fixed 4-input, 2-stage, unframed group sum stage.

Parameters:
NUM_IN, 4, number of parallel inputs per beat; power of 2, >= 2
IN_W, 16, signed width of each input lane
OUT_W, 20, signed width of out_data and of the accumulator; OUT_W >= IN_W + log2(NUM_IN)
SAT_EN, 1, 1 = saturate the accumulator to the OUT_W range; 0 = two's-complement wrap

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  beat qualifier
in_first  in  1  first beat of a group; sampled only when in_valid=1
in_last  in  1  last beat of a group; sampled only when in_valid=1
in_data  in  NUM_IN*IN_W  packed signed lanes; lane i = bits [i*IN_W +: IN_W]
out_valid  out  1  one-cycle pulse; group result is present
out_data  out  OUT_W  signed group sum
out_overflow  out  1  saturation or wrap occurred anywhere in the group; valid with out_valid

Behaviour:
- Reset (async, rst=1): all pipeline regs, valid/first/last sidebands, accumulator, open-group flag, out_valid, out_data and out_overflow go to 0 immediately. A partial group is discarded with no output. First beat is accepted on the first rising edge after rst deasserts.
- Tree:
  - L = log2(NUM_IN) registered levels. Each level adds adjacent pairs with sign extension, growing 1 bit per level, so no overflow occurs inside the tree.
  - in_valid/in_first/in_last are delayed L cycles alongside the tree.
  - Tree registers are enabled every cycle; bubbles simply carry valid=0.
- Accumulate stage (edge L+1), acting on tree output s with delayed flags v/f/l:
  - v=0: hold acc and the open flag; out_valid=0.
  - v=1, f=1 or no group open: n = sext(s). Otherwise n = acc + sext(s), computed at OUT_W+1 bits.
  - If n is outside the OUT_W signed range: SAT_EN=1 clamps to max/min; SAT_EN=0 truncates. In both cases the sticky overflow is set. The sticky overflow restarts on a first/implicit-first beat.
  - l=0: acc <= n; open <= 1.
  - l=1: out_data <= n; out_overflow <= sticky including this beat; out_valid <= 1 for one cycle; acc <= 0; open <= 0.
- Latency: a beat with in_last at edge t produces out_valid at edge t+L+1 (3 for NUM_IN=4).
- Throughput: 1 beat/cycle, no backpressure; back-to-back groups with no gap are supported.
- Boundary cases:
  - in_first while a group is open: restarts the group; the partial group is dropped and produces no output.
  - first and last on the same beat: 1-beat group, out_data = tree sum.
  - A valid beat without first and with no group open: implicit first (accumulates from 0).
  - Flags on invalid beats are ignored.
- out_data and out_overflow hold their last value when out_valid=0.

Decomposition:
- Shared header (DEFINE.vh): defaults for IN_W and OUT_W, and a CLOG2 constant function/macro.
- One natural sub-module, conv_adder_tree: NUM_IN, IN_W; purely the registered tree plus a delayed sideband bus.
- conv_group_acc instantiates conv_adder_tree and adds the accumulate/saturate/framing logic.

Test Plan:
Defaults apply (NUM_IN=4, IN_W=16, OUT_W=20, SAT_EN=1).
1. One beat, first=last=1, lanes 1,2,3,4 -> out_valid pulses 3 cycles later, out_data=10, out_overflow=0.
2. Three beats with lane sums 10, 20, -5; first on beat 1, last on beat 3, a 2-cycle bubble between beats 2 and 3 -> single pulse 3 cycles after beat 3, out_data=25.
3. Two back-to-back groups (sums 7 | 100,-1), no gap -> pulses carry 7 then 99, last-beat-to-pulse spacing preserved, no merging.
4. Saturation: 5 beats, all lanes 32767 (131068 per beat) -> 524287 with overflow=1. Repeat with -32768 -> -524288, overflow=1. SAT_EN=0 build, 5 beats of 131068 -> -393236, overflow=1.
5. Restart: first beat (sum 50), then another first beat (sum 4) with last -> single output 4. Beat without first after a completed group (sum 9, last) -> 9.
6. Reset mid-group: 2 beats accepted, rst pulsed asynchronously between edges -> all outputs 0 immediately, no pulse. Then 1-beat group of lanes 1,1,1,1 -> out_data=4 at the expected latency.
